// File: rtl/post_core_argmax.sv
// post_core_argmax
//   Output-layer decision logic for the SNN core. Per-neuron saturating
//   spike counters accumulate over one image's core phase. When the image
//   ends, a linear scan (one counter per cycle) finds the winning neuron,
//   with ties going to the lowest index. In test mode the winner is bound
//   to test_label in a label table. In classify mode the winner's stored
//   label is reported. The result is offered over a valid/ready handshake.
//
// Ports
//   clk, rst        clock, synchronous active-high reset
//   mode            00 idle, 01 train, 10 test (assign label), 11 classify
//   test_label      label of the current image (test mode)
//   coring          core phase active
//   ops             output-neuron spike vector for this time unit
//   tu_incre        time-unit strobe; qualifies ops and done_core_img
//   done_core_img   last time unit of the image
//   res_ready       consumer accepts the result
//   res_valid       result available, held until res_ready
//   image_label     classify: winner's label; test: label written
//   win_index       index of the winning neuron
//   win_count       spike count of the winning neuron
//   no_spike        all counters were zero at the end of the image
//   busy            high in every state other than COUNT

// Single saturating spike counter for one output neuron.
module post_core_argmax_cnt #(
    parameter int CW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          inc,
    input  logic          clr,
    output logic [CW-1:0] cnt,
    output logic [CW-1:0] cnt_nxt
);
    always_comb begin
        cnt_nxt = cnt;
        if (clr)
            cnt_nxt = '0;
        else if (inc && cnt != {CW{1'b1}})
            cnt_nxt = cnt + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) cnt <= '0;
        else     cnt <= cnt_nxt;
    end
endmodule

module post_core_argmax #(
    parameter int N  = 8,
    parameter int CW = 8,
    parameter int LW = 8,
    parameter int IW = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [1:0]    mode,
    input  logic [LW-1:0] test_label,
    input  logic          coring,
    input  logic [N-1:0]  ops,
    input  logic          tu_incre,
    input  logic          done_core_img,
    input  logic          res_ready,
    output logic          res_valid,
    output logic [LW-1:0] image_label,
    output logic [IW-1:0] win_index,
    output logic [CW-1:0] win_count,
    output logic          no_spike,
    output logic          busy
);
    typedef enum logic [1:0] {COUNT, SCAN, COMMIT, OUTPUT} state_t;

    localparam logic [1:0] M_TRAIN = 2'b01;
    localparam logic [1:0] M_TEST  = 2'b10;

    state_t               state;
    logic [1:0]           mode_q;
    logic [IW-1:0]        scan_idx;
    logic [IW-1:0]        best_idx;
    logic [CW-1:0]        best;
    logic [N-1:0][LW-1:0] label_tbl;
    logic [N-1:0][CW-1:0] cnt_arr;
    logic [N-1:0][CW-1:0] cnt_nxt;

    // Strobes only count in COUNT; any other state ignores the upstream.
    logic cnt_en, done_acc, clr;
    assign cnt_en   = (state == COUNT) && coring && tu_incre && (mode != 2'b00);
    assign done_acc = cnt_en && done_core_img;
    assign clr      = (state == OUTPUT) && res_valid && res_ready;
    assign busy     = (state != COUNT);

    for (genvar i = 0; i < N; i++) begin : g_cnt
        post_core_argmax_cnt #(.CW(CW)) u_cnt (
            .clk     (clk),
            .rst     (rst),
            .inc     (cnt_en & ops[i]),
            .clr     (clr),
            .cnt     (cnt_arr[i]),
            .cnt_nxt (cnt_nxt[i])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= COUNT;
            mode_q      <= '0;
            scan_idx    <= '0;
            best_idx    <= '0;
            best        <= '0;
            label_tbl   <= '1;
            res_valid   <= 1'b0;
            image_label <= '0;
            win_index   <= '0;
            win_count   <= '0;
            no_spike    <= 1'b0;
        end else begin
            case (state)
                COUNT: begin
                    if (done_acc) begin
                        mode_q <= mode;
                        if (mode == M_TRAIN) begin
                            // Train skips the scan; no_spike includes this
                            // cycle's spikes, hence the next-state view.
                            state     <= OUTPUT;
                            res_valid <= 1'b1;
                            no_spike  <= ~|cnt_nxt;
                        end else begin
                            state    <= SCAN;
                            scan_idx <= '0;
                            best     <= '0;
                            best_idx <= '0;
                        end
                    end
                end
                SCAN: begin
                    // Strictly greater: equal counts keep the lower index.
                    if (cnt_arr[scan_idx] > best) begin
                        best     <= cnt_arr[scan_idx];
                        best_idx <= scan_idx;
                    end
                    if (scan_idx == IW'(N-1)) state    <= COMMIT;
                    else                      scan_idx <= scan_idx + 1'b1;
                end
                COMMIT: begin
                    no_spike  <= (best == '0);
                    win_index <= best_idx;
                    win_count <= best;
                    if (mode_q == M_TEST) begin
                        // A silent image carries no evidence; leave the table.
                        if (best != '0) label_tbl[best_idx] <= test_label;
                        image_label <= test_label;
                    end else begin
                        image_label <= (best == '0) ? {LW{1'b1}} : label_tbl[best_idx];
                    end
                    res_valid <= 1'b1;
                    state     <= OUTPUT;
                end
                OUTPUT: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        state     <= COUNT;
                    end
                end
                default: state <= COUNT;
            endcase
        end
    end
endmodule

// File: tb/tb_post_core_argmax.sv
module tb_post_core_argmax;
    localparam int N = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] mode;
    logic [7:0] test_label;
    logic       coring, tu_incre, done_core_img, res_ready;
    logic [N-1:0] ops;

    logic       res_valid, no_spike, busy;
    logic [7:0] image_label;
    logic [2:0] win_index;
    logic [7:0] win_count;

    // Narrow-counter copy sharing all inputs, used for saturation.
    logic       res_valid2, no_spike2, busy2;
    logic [7:0] image_label2;
    logic [2:0] win_index2;
    logic [3:0] win_count2;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    post_core_argmax #(.N(8), .CW(8), .LW(8), .IW(3)) dut (
        .clk(clk), .rst(rst), .mode(mode), .test_label(test_label),
        .coring(coring), .ops(ops), .tu_incre(tu_incre),
        .done_core_img(done_core_img), .res_ready(res_ready),
        .res_valid(res_valid), .image_label(image_label),
        .win_index(win_index), .win_count(win_count),
        .no_spike(no_spike), .busy(busy)
    );

    post_core_argmax #(.N(8), .CW(4), .LW(8), .IW(3)) dut4 (
        .clk(clk), .rst(rst), .mode(mode), .test_label(test_label),
        .coring(coring), .ops(ops), .tu_incre(tu_incre),
        .done_core_img(done_core_img), .res_ready(res_ready),
        .res_valid(res_valid2), .image_label(image_label2),
        .win_index(win_index2), .win_count(win_count2),
        .no_spike(no_spike2), .busy(busy2)
    );

    task automatic step();
        @(posedge clk); #1;
    endtask

    // Neuron i spikes c[i] times; done_core_img rides on the last strobe.
    // Returns one cycle after the accepting edge (cycle t+1).
    task automatic run_image(input logic [1:0] m, input logic [7:0] lbl, input int c[8]);
        int mx = 1;
        foreach (c[i]) if (c[i] > mx) mx = c[i];
        mode = m; test_label = lbl; coring = 1'b1;
        for (int k = 0; k < mx; k++) begin
            tu_incre = 1'b1;
            for (int i = 0; i < N; i++) ops[i] = (c[i] > k);
            done_core_img = (k == mx - 1);
            step();
        end
        tu_incre = 1'b0; done_core_img = 1'b0; ops = '0; coring = 1'b0;
    endtask

    // Cycles from t+1 until res_valid, counted so t+1 reads as 1.
    task automatic wait_result(output int lat);
        lat = 1;
        while (!res_valid && lat < 50) begin
            step();
            lat++;
        end
    endtask

    task automatic ack();
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step(); step();
        rst = 1'b0;
        tests++; if (res_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %0b want 0", res_valid); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %0b want 0", busy); end
        tests++; if ({image_label, win_index, win_count, no_spike} !== 20'h0) begin
            fails++; $display("FAIL reset_outputs: got %0h want 0", {image_label, win_index, win_count, no_spike});
        end
    endtask

    task automatic test_classify_unassigned();
        int lat;
        run_image(2'b11, 8'h00, '{1, 2, 0, 1, 2, 3, 0, 1});
        tests++; if (busy !== 1'b1) begin fails++; $display("FAIL cls_busy: got %0b want 1", busy); end
        wait_result(lat);
        tests++; if (lat != N + 2) begin fails++; $display("FAIL cls_latency: got %0d want %0d", lat, N + 2); end
        tests++; if (win_index !== 3'd5) begin fails++; $display("FAIL cls_index: got %0d want 5", win_index); end
        tests++; if (win_count !== 8'd3) begin fails++; $display("FAIL cls_count: got %0d want 3", win_count); end
        tests++; if (image_label !== 8'hFF) begin fails++; $display("FAIL cls_label: got %0h want ff", image_label); end
        tests++; if (no_spike !== 1'b0) begin fails++; $display("FAIL cls_nospike: got %0b want 0", no_spike); end
        ack();
        tests++; if (busy !== 1'b0 || res_valid !== 1'b0) begin
            fails++; $display("FAIL cls_handshake: got busy=%0b valid=%0b want 0 0", busy, res_valid);
        end
    endtask

    task automatic test_assign();
        int lat;
        run_image(2'b10, 8'd7, '{2, 1, 4, 0, 2, 1, 0, 2});
        wait_result(lat);
        tests++; if (lat != N + 2) begin fails++; $display("FAIL tst_latency: got %0d want %0d", lat, N + 2); end
        tests++; if (win_index !== 3'd2 || win_count !== 8'd4) begin
            fails++; $display("FAIL tst_winner: got idx=%0d cnt=%0d want idx=2 cnt=4", win_index, win_count);
        end
        tests++; if (image_label !== 8'd7) begin fails++; $display("FAIL tst_label: got %0h want 7", image_label); end
        ack();
        run_image(2'b11, 8'h00, '{0, 0, 3, 1, 0, 0, 2, 0});
        wait_result(lat);
        tests++; if (win_index !== 3'd2 || image_label !== 8'd7) begin
            fails++; $display("FAIL tst_lookup: got idx=%0d label=%0h want idx=2 label=7", win_index, image_label);
        end
        ack();
    endtask

    task automatic test_tie();
        int lat;
        run_image(2'b11, 8'h00, '{0, 5, 2, 0, 3, 0, 5, 1});
        wait_result(lat);
        tests++; if (win_index !== 3'd1 || win_count !== 8'd5) begin
            fails++; $display("FAIL tie_winner: got idx=%0d cnt=%0d want idx=1 cnt=5", win_index, win_count);
        end
        tests++; if (image_label !== 8'hFF) begin fails++; $display("FAIL tie_label: got %0h want ff", image_label); end
        ack();
    endtask

    task automatic test_saturation();
        int lat;
        run_image(2'b11, 8'h00, '{20, 0, 0, 0, 0, 0, 0, 0});
        wait_result(lat);
        tests++; if (win_count !== 8'd20) begin fails++; $display("FAIL sat_wide: got %0d want 20", win_count); end
        tests++; if (win_count2 !== 4'd15 || win_index2 !== 3'd0) begin
            fails++; $display("FAIL sat_narrow: got cnt=%0d idx=%0d want cnt=15 idx=0", win_count2, win_index2);
        end
        ack();
        // Silent image in test mode: reports no_spike, must not write.
        run_image(2'b10, 8'd9, '{0, 0, 0, 0, 0, 0, 0, 0});
        wait_result(lat);
        tests++; if (no_spike !== 1'b1 || win_count !== 8'd0) begin
            fails++; $display("FAIL zero_nospike: got ns=%0b cnt=%0d want ns=1 cnt=0", no_spike, win_count);
        end
        tests++; if (image_label !== 8'd9) begin fails++; $display("FAIL zero_label: got %0h want 9", image_label); end
        ack();
        run_image(2'b11, 8'h00, '{3, 0, 1, 0, 0, 0, 0, 0});
        wait_result(lat);
        tests++; if (win_index !== 3'd0 || image_label !== 8'hFF) begin
            fails++; $display("FAIL zero_table: got idx=%0d label=%0h want idx=0 label=ff", win_index, image_label);
        end
        ack();
        run_image(2'b11, 8'h00, '{1, 0, 2, 0, 0, 0, 0, 0});
        wait_result(lat);
        tests++; if (win_index !== 3'd2 || image_label !== 8'd7) begin
            fails++; $display("FAIL keep_table: got idx=%0d label=%0h want idx=2 label=7", win_index, image_label);
        end
        ack();
    endtask

    task automatic test_backpressure();
        int lat;
        int bad = 0;
        run_image(2'b11, 8'h00, '{0, 0, 0, 0, 3, 1, 0, 0});
        wait_result(lat);
        tests++; if (win_index !== 3'd4 || win_count !== 8'd3) begin
            fails++; $display("FAIL bp_winner: got idx=%0d cnt=%0d want idx=4 cnt=3", win_index, win_count);
        end
        // Strobes and a mode change while stalled must all be ignored.
        coring = 1'b1; tu_incre = 1'b1; ops = '1; done_core_img = 1'b1; mode = 2'b10; test_label = 8'h55;
        for (int k = 0; k < 10; k++) begin
            step();
            if (res_valid !== 1'b1 || win_index !== 3'd4 || win_count !== 8'd3 ||
                image_label !== 8'hFF || no_spike !== 1'b0) bad++;
        end
        coring = 1'b0; tu_incre = 1'b0; ops = '0; done_core_img = 1'b0;
        tests++; if (bad != 0) begin fails++; $display("FAIL bp_stable: got %0d unstable cycles want 0", bad); end
        ack();
        run_image(2'b11, 8'h00, '{0, 0, 0, 2, 1, 0, 0, 0});
        wait_result(lat);
        tests++; if (win_index !== 3'd3 || win_count !== 8'd2) begin
            fails++; $display("FAIL bp_cleared: got idx=%0d cnt=%0d want idx=3 cnt=2", win_index, win_count);
        end
        ack();
    endtask

    task automatic test_reset_mid_scan();
        int lat;
        run_image(2'b11, 8'h00, '{0, 0, 4, 0, 0, 0, 0, 0});
        step(); step();                 // now in cycle t+3, still in SCAN
        tests++; if (busy !== 1'b1) begin fails++; $display("FAIL rs_busy_scan: got %0b want 1", busy); end
        rst = 1'b1;
        step();
        rst = 1'b0;
        tests++; if (busy !== 1'b0 || res_valid !== 1'b0 || win_count !== 8'd0 || image_label !== 8'd0) begin
            fails++; $display("FAIL rs_abort: got busy=%0b valid=%0b cnt=%0d label=%0h want all 0",
                              busy, res_valid, win_count, image_label);
        end
        run_image(2'b01, 8'd3, '{0, 0, 2, 0, 0, 0, 0, 0});
        wait_result(lat);
        tests++; if (lat != 1) begin fails++; $display("FAIL train_latency: got %0d want 1", lat); end
        tests++; if (no_spike !== 1'b0 || win_count !== 8'd0 || image_label !== 8'd0) begin
            fails++; $display("FAIL train_outputs: got ns=%0b cnt=%0d label=%0h want 0 0 0", no_spike, win_count, image_label);
        end
        ack();
        run_image(2'b01, 8'd3, '{0, 0, 0, 0, 0, 0, 0, 0});
        wait_result(lat);
        tests++; if (no_spike !== 1'b1) begin fails++; $display("FAIL train_nospike: got %0b want 1", no_spike); end
        ack();
        run_image(2'b11, 8'h00, '{0, 0, 2, 0, 0, 0, 0, 0});
        wait_result(lat);
        tests++; if (win_index !== 3'd2 || image_label !== 8'hFF) begin
            fails++; $display("FAIL rs_table: got idx=%0d label=%0h want idx=2 label=ff", win_index, image_label);
        end
        ack();
    endtask

    initial begin
        rst = 1'b1; mode = 2'b00; test_label = '0; coring = 1'b0; ops = '0;
        tu_incre = 1'b0; done_core_img = 1'b0; res_ready = 1'b0;
        step();
        test_reset();
        test_classify_unassigned();
        test_assign();
        test_tie();
        test_saturation();
        test_backpressure();
        test_reset_mid_scan();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/post_core_argmax.md
Name: post_core_argmax

Overview:
- Parametrised successor to the output-layer decision logic of the SNN core.
- Counts spikes per output neuron over one image's core phase, then scans for the winning neuron over N cycles.
- Test mode: binds `test_label` to the winner in an internal label table. Classify mode: reports the winner's stored label.
- Adds saturating counters, deterministic tie-break, no-spike detection, unassigned-label detection and a valid/ready result handshake.

Parameters:
- N, 8, number of output neurons.
- CW, 8, spike-counter width.
- LW, 8, label width.
- IW, 3, neuron index width; must satisfy 2^IW >= N.

Ports:
- clk  in  1  single clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- mode  in  2  00 idle, 01 train, 10 test (assign label), 11 classify.
- test_label  in  LW  label of the current image; used in test mode.
- coring  in  1  core phase active.
- ops  in  N  output-neuron spike vector for the current time unit.
- tu_incre  in  1  time-unit strobe; ops is sampled when coring && tu_incre.
- done_core_img  in  1  marks the last time unit of the image; qualified by coring && tu_incre.
- res_ready  in  1  consumer accepts the result.
- res_valid  out  1  result available; held until res_ready.
- image_label  out  LW  classify: label of the winner; test: test_label written.
- win_index  out  IW  index of the winning neuron.
- win_count  out  CW  spike count of the winning neuron.
- no_spike  out  1  all counters were zero at the end of the image.
- busy  out  1  high in every state other than COUNT.

Behaviour:
- Reset (synchronous): state COUNT; all counters 0; every label-table entry all-ones (UNASSIGNED); all outputs 0. A reset asserted in any state aborts the operation, and no table write occurs that cycle.
- States: COUNT, SCAN, COMMIT, OUTPUT.
- COUNT:
  - When coring && tu_incre && mode != 00, each counter i with ops[i]=1 increments, saturating at 2^CW-1 (no wrap).
  - When done_core_img is also high, that cycle's spikes are still counted and mode is latched into mode_q.
  - mode_q=01 goes to OUTPUT. mode_q=10 or 11 goes to SCAN with scan index 0, best=0, best_idx=0.
  - With mode 00, counting is disabled and done_core_img is ignored.
- SCAN:
  - One counter per cycle, indices 0..N-1, so exactly N cycles.
  - Replace best/best_idx only on strictly greater, so ties resolve to the lowest index.
  - After index N-1, go to COMMIT.
- COMMIT (1 cycle):
  - no_spike = (best == 0).
  - mode_q=10: if !no_spike, table[best_idx] <= test_label; image_label <= test_label.
  - mode_q=11: image_label <= table[best_idx], or all-ones if no_spike.
  - win_index <= best_idx; win_count <= best. Go to OUTPUT.
- OUTPUT:
  - res_valid=1. All result outputs are stable while res_valid && !res_ready.
  - For train mode, win_index, win_count and image_label keep their previous values; no_spike is computed from the counters.
  - On res_valid && res_ready: clear all counters, res_valid <= 0, return to COUNT.
- Latency: done_core_img accepted in cycle t gives:
  - test/classify: SCAN t+1..t+N, COMMIT t+N+1, res_valid from t+N+2.
  - train: res_valid from t+1.
- While busy, tu_incre, ops and done_core_img are ignored. The upstream must hold the next image until the handshake completes.
- Changing mode while busy has no effect; mode_q governs the operation.
- Re-testing the same winner overwrites its label (last write wins).

Test Plan:
1. Reset then classify with no prior test: ops strobes give neuron 5 three spikes and the others fewer -> win_index=5, win_count=3, image_label=8'hFF (unassigned), res_valid at t+N+2.
2. Test mode, test_label=7, neuron 2 spikes 4 times and the others ≤2 -> table[2]=7, image_label=7. A following classify image won by neuron 2 -> image_label=7.
3. Tie: neurons 1 and 6 each spike 5 times and the others fewer -> win_index=1.
4. Saturation: CW=4, neuron 0 spikes 20 times -> win_count=15, no wrap. Zero spikes on all neurons in test mode -> no_spike=1 and the table is unchanged.
5. Backpressure: hold res_ready=0 for 10 cycles with strobes applied -> outputs stable, counters unchanged. On res_ready=1, counters read 0 next image.
6. Assert rst during SCAN (cycle t+3) -> next cycle state COUNT, outputs 0, table all-ones; train-mode done -> res_valid at t+1, table unchanged.
